lookup_arbiter: RTL and testbench

LOOKUP_ARBITER -- requirements
Module: lookup_arbiter

---
 rtl/lookup_arbiter.sv | 116 +++++++++++
 tb/tb_lookup_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_arbiter.sv
// lookup_arbiter: one-op-per-cycle arbiter between table updates and two lookup requesters.
// Define LOOKUP_ARB_INIT_CLEAR_EN to zero the whole table after reset before accepting traffic.
module lookup_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 192,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [1:0]            rd_valid,
  output logic [1:0]            rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr0,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  init_done
);
  localparam int BW = $clog2(MAX_WR_BURST + 1);
  typedef enum logic [1:0] {RST, INIT, RUN} state_t;
  state_t                state_q, state_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic                  rr_q, rr_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [2:0]            vld_q, vld_d;
  logic [2:0]            id_q, id_d;
  logic                  init_done_q, init_done_d;
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif
  logic                  run, wr_gnt, rd_gnt, rd_sel;
  always_comb begin
    run      = state_q == RUN;
    wr_gnt   = run & wr_valid & ((burst_q < BW'(MAX_WR_BURST)) | ~|rd_valid);
    rd_gnt   = run & ~wr_gnt & |rd_valid;
    rd_sel   = rd_valid[rr_q] ? rr_q : ~rr_q;
    wr_ready = wr_gnt;
    rd_ready = rd_gnt ? (rd_sel ? 2'b10 : 2'b01) : 2'b00;
    burst_d  = wr_gnt ? (burst_q == BW'(MAX_WR_BURST) ? burst_q : burst_q + BW'(1)) : '0;
    rr_d     = rd_gnt ? ~rd_sel : rr_q;
    we_d     = wr_gnt;
    waddr_d  = wr_gnt ? wr_addr : waddr_q;
    wdata_d  = wr_gnt ? wr_data : wdata_q;
    raddr_d  = rd_gnt ? (rd_sel ? rd_addr1 : rd_addr0) : raddr_q;
    // the slot id is zero when empty so rsp_id idles at its reset value
    vld_d    = {vld_q[1:0], rd_gnt};
    id_d     = {id_q[1:0], rd_gnt & rd_sel};
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
    init_cnt_d = init_cnt_q;
    state_d    = state_q == RST ? INIT : (state_q == INIT && &init_cnt_q) ? RUN : state_q;
    if (state_q == INIT) begin
      we_d       = 1'b1;
      waddr_d    = init_cnt_q;
      wdata_d    = '0;
      init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
    end
    init_done_d = state_d == RUN;
`else
    state_d     = RUN;
    init_done_d = 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST;
      burst_q     <= '0;
      rr_q        <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      vld_q       <= '0;
      id_q        <= '0;
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
`else
      init_done_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      rr_q        <= rr_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      vld_q       <= vld_d;
      id_q        <= id_d;
      init_done_q <= init_done_d;
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
      init_cnt_q  <= init_cnt_d;
`endif
    end
  end
  assign ram_write_enable = we_q;
  assign ram_write_addr   = waddr_q;
  assign ram_write_data   = wdata_q;
  assign ram_read_addr    = raddr_q;
  assign rsp_valid        = vld_q[2];
  assign rsp_id           = id_q[2];
  assign rsp_data         = ram_read_data;
  assign init_done        = init_done_q;
endmodule

// File: tb/tb_lookup_arbiter.sv
// tb_lookup_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_lookup_arbiter;
  localparam int AW = 8, DW = 192, MAXB = 4;
  logic clk = 0, reset_n = 0;
  logic wr_valid = 0, rsp_valid, rsp_id, ram_write_enable, init_done, wr_ready;
  logic [1:0] rd_valid = 0, rd_ready;
  logic [AW-1:0] wr_addr = 0, rd_addr0 = 0, rd_addr1 = 0, ram_write_addr, ram_read_addr;
  logic [DW-1:0] wr_data = 0, rsp_data, ram_write_data, ram_read_data, rd1, rd2;
  logic [DW-1:0] tmem [256];
  lookup_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WR_BURST(MAXB)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr0(rd_addr0),
    .rd_addr1(rd_addr1), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr), .ram_write_data(ram_write_data),
    .ram_write_enable(ram_write_enable), .ram_read_data(ram_read_data), .init_done(init_done));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_write_enable) tmem[ram_write_addr] <= ram_write_data;
    rd1 <= tmem[ram_read_addr];
    rd2 <= rd1;
  end
  assign ram_read_data = rd2;
  typedef struct {int due; logic id; logic [DW-1:0] data;} rsp_t;
  rsp_t q[$];
  int log_cyc[$];
  logic log_id[$];
  logic [DW-1:0] log_data[$];
  logic [DW-1:0] m_mem [256];
  int checks = 0, errors = 0, cyc = 0, m_burst = 0, init_left = 0, last_hs = 0;
  logic m_rr = 0, run_m = 0, prev_run = 0, p_we = 0, g_wr = 0;
  logic [1:0] g_rd = 0;
  logic [AW-1:0] p_wa = 0;
  logic [DW-1:0] p_wd = 0;
  logic wv = 0;
  logic [1:0] rv = 0;
  logic [AW-1:0] wa = 0, ra0 = 0, ra1 = 0;
  logic [DW-1:0] wd = 0;
  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  // the model: one op per cycle, writes win until the burst cap while reads wait, reads answer 3 cycles later
  task automatic step();
    logic ew, sel;
    logic [1:0] er;
    rsp_t r;
    ew  = run_m && wr_valid && (m_burst < MAXB || rd_valid == 2'b00);
    er  = 2'b00;
    sel = 1'b0;
    if (run_m && !ew && rd_valid != 2'b00) begin
      sel = rd_valid[m_rr] ? m_rr : !m_rr;
      er  = sel ? 2'b10 : 2'b01;
    end
    chk("wr_ready", DW'(wr_ready), DW'(ew));
    chk("rd_ready", DW'(rd_ready), DW'(er));
    g_wr = wr_ready;
    g_rd = rd_ready;
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
    chk("init_done", DW'(init_done), DW'(run_m));
`else
    chk("init_done", DW'(init_done), DW'(1));
`endif
    if (prev_run) begin
      chk("ram_we", DW'(ram_write_enable), DW'(p_we));
      if (p_we) begin
        chk("ram_waddr", DW'(ram_write_addr), DW'(p_wa));
        chk("ram_wdata", ram_write_data, p_wd);
      end
    end
    if (rsp_valid) begin
      log_cyc.push_back(cyc);
      log_id.push_back(rsp_id);
      log_data.push_back(rsp_data);
    end
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      chk("rsp_valid", DW'(rsp_valid), DW'(1));
      chk("rsp_id", DW'(rsp_id), DW'(r.id));
      chk("rsp_data", rsp_data, r.data);
    end else chk("rsp_valid_idle", DW'(rsp_valid), DW'(0));
    if (ew) begin
      m_mem[wr_addr] = wr_data;
      m_burst = m_burst < MAXB ? m_burst + 1 : MAXB;
    end else m_burst = 0;
    if (er != 2'b00) begin
      q.push_back('{cyc + 3, sel, m_mem[sel ? rd_addr1 : rd_addr0]});
      m_rr = !sel;
      last_hs = cyc;
    end
    p_we = ew; p_wa = wr_addr; p_wd = wr_data; prev_run = run_m;
    cyc++;
  endtask
  task automatic cycle();
    @(negedge clk);
    reset_n = 1; wr_valid = wv; wr_addr = wa; wr_data = wd;
    rd_valid = rv; rd_addr0 = ra0; rd_addr1 = ra1;
    #1 step();
    @(posedge clk);
    if (init_left > 0) init_left--;
    else run_m = 1;
  endtask
  task automatic idle(input int n);
    wv = 0; rv = 0;
    for (int i = 0; i < n; i++) cycle();
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0; wr_valid = 1; rd_valid = 2'b11;
    #1;
    chk("rst_wr_ready", DW'(wr_ready), DW'(0));
    chk("rst_rd_ready", DW'(rd_ready), DW'(0));
    chk("rst_rsp_valid", DW'(rsp_valid), DW'(0));
    chk("rst_rsp_id", DW'(rsp_id), DW'(0));
    chk("rst_ram_we", DW'(ram_write_enable), DW'(0));
    chk("rst_ram_waddr", DW'(ram_write_addr), DW'(0));
    chk("rst_ram_raddr", DW'(ram_read_addr), DW'(0));
    chk("rst_ram_wdata", ram_write_data, DW'(0));
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
    chk("rst_init_done", DW'(init_done), DW'(0));
    init_left = 256;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
`else
    chk("rst_init_done", DW'(init_done), DW'(1));
    init_left = 0;
`endif
    q.delete();
    m_burst = 0; m_rr = 0; run_m = 0; prev_run = 0; p_we = 0;
    wv = 0; rv = 0;
    @(posedge clk);
  endtask
  initial begin
    int n;
    logic [DW-1:0] d;
    logic [9:0] wvec;
    logic [1:0] rseq [4];
    for (int i = 0; i < 256; i++) begin
      tmem[i] = {6{32'(i * 7 + 1)}};
      m_mem[i] = {6{32'(i * 7 + 1)}};
    end
    do_reset();
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
    idle(257);
`endif
    idle(1);
    // round-robin from a fresh pointer
    n = log_id.size();
    rv = 2'b11; ra0 = 8'h01; ra1 = 8'h02;
    for (int i = 0; i < 4; i++) begin cycle(); rseq[i] = g_rd; end
    idle(4);
    chk("rr_g0", DW'(rseq[0]), DW'(2'b01));
    chk("rr_g1", DW'(rseq[1]), DW'(2'b10));
    chk("rr_g2", DW'(rseq[2]), DW'(2'b01));
    chk("rr_g3", DW'(rseq[3]), DW'(2'b10));
    chk("rr_nrsp", DW'(log_id.size() - n), DW'(4));
    if (log_id.size() - n == 4) begin
      chk("rr_ids", DW'({log_id[n], log_id[n+1], log_id[n+2], log_id[n+3]}), DW'(4'b0101));
      chk("rr_consec", DW'(log_cyc[n+3] - log_cyc[n]), DW'(3));
    end
    // single lookup
    wv = 1; wa = 8'h10; wd = {24{8'hA5}}; rv = 0;
    cycle();
    chk("sl_wr", DW'(g_wr), DW'(1));
    wv = 0; rv = 2'b01; ra0 = 8'h10;
    cycle();
    n = log_id.size();
    rv = 0;
    idle(4);
    chk("sl_nrsp", DW'(log_id.size() - n), DW'(1));
    if (log_id.size() > n) begin
      chk("sl_lat", DW'(log_cyc[n] - last_hs), DW'(3));
      chk("sl_id", DW'(log_id[n]), DW'(0));
      chk("sl_data", log_data[n], {24{8'hA5}});
    end
    // write and read to the same address requested together
    d = rnd();
    wv = 1; wa = 8'h20; wd = d; rv = 2'b01; ra0 = 8'h20;
    cycle();
    chk("wr_first", DW'({g_wr, g_rd}), DW'(3'b100));
    wv = 0;
    cycle();
    chk("rd_next", DW'(g_rd), DW'(2'b01));
    n = log_id.size();
    idle(4);
    if (log_id.size() > n) chk("raw_data", log_data[n], d);
    else chk("raw_nrsp", DW'(0), DW'(1));
    // write burst cap with a waiting reader
    wv = 1; wa = 8'h30; wd = rnd(); rv = 2'b10; ra1 = 8'h30;
    wvec = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      wvec = {wvec[8:0], g_wr};
      if (g_wr) begin wa = wa + 1; wd = rnd(); end
    end
    chk("burst_seq", DW'(wvec), DW'(10'b1111011110));
    idle(4);
    // reset with two lookups in flight
    rv = 2'b11; ra0 = 8'h10; ra1 = 8'h20;
    cycle(); cycle();
    do_reset();
    n = log_id.size();
`ifdef LOOKUP_ARB_INIT_CLEAR_EN
    idle(257);
    n = log_id.size();
    rv = 2'b01; ra0 = 8'hFF;
    cycle(); cycle();
    rv = 0;
    idle(4);
    if (log_id.size() > n) chk("init_ff", log_data[n], DW'(0));
    else chk("init_nrsp", DW'(0), DW'(1));
    n = log_id.size();
`endif
    idle(6);
    chk("flush_nrsp", DW'(log_id.size() - n), DW'(0));
    // randomized traffic with requesters that hold until accepted
    for (int i = 0; i < 500; i++) begin
      if (g_wr || !wv) begin wv = ($urandom % 3) == 0; wa = AW'($urandom % 8); wd = rnd(); end
      if (g_rd[0] || !rv[0]) begin rv[0] = ($urandom % 3) == 0; ra0 = AW'($urandom % 8); end
      if (g_rd[1] || !rv[1]) begin rv[1] = ($urandom % 3) == 0; ra1 = AW'($urandom % 8); end
      cycle();
    end
    idle(5);
    chk("q_drained", DW'(q.size()), DW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
